// File: rtl/gpio_cfg_pkg.sv
// Purpose: shared constants, FSM state type and config-word field map for the GPIO config chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_cfg_pkg;

  // Width of one GPIO control block word; matches the tie-cell defaults block.
  localparam int CFG_W        = 10;
  localparam int NUM_GPIO_DEF = 19;

  // Counter widths: bits remaining (0..CFG_W) and half-period / load cycles (CLK_DIV <= 15).
  localparam int BIT_CNT_W = $clog2(CFG_W + 1);
  localparam int DIV_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_LOAD    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Field positions inside a config word, shared with the GPIO control block.
  // The word holds eight single-bit controls plus dm[1:0]; dm[2] is fixed by the
  // control block's own tie default and is not carried on the chain.
  localparam int CFG_MGMT_ENA    = 0;
  localparam int CFG_OE_OVR      = 1;
  localparam int CFG_HOLD_OVR    = 2;
  localparam int CFG_INP_DIS     = 3;
  localparam int CFG_IB_MODE_SEL = 4;
  localparam int CFG_ANALOG_ENA  = 5;
  localparam int CFG_ANALOG_SEL  = 6;
  localparam int CFG_ANALOG_POL  = 7;
  localparam int CFG_DM_LSB      = 8;
  localparam int CFG_DM_MSB      = 9;

endpackage

// File: rtl/gpio_cfg_serial_loader_sclk_gen.sv
// Purpose: serial_clock generator; low then high for CLK_DIV cycles each, with rise/fall strobes.
// Latency: clock starts low on the first enabled cycle; strobes mark the cycle before each edge.
// Backpressure: none; disabling forces the clock low and restarts the phase.
module gpio_cfg_sclk_gen
  import gpio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             last;

  // Next half-period count and phase; strobes fire on the last cycle of a phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rise    = 1'b0;
    fall    = 1'b0;
    last    = (cnt_q == DIV_W'(CLK_DIV - 1));
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (last) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
      rise    = ~phase_q;
      fall    = phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sclk = phase_q;

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Purpose: fetches per-GPIO config words and shifts them out on two serial chains, then pulses load.
// Latency: busy for NUM_GPIO*(2+2*CLK_DIV*CFG_W)+CLK_DIV cycles after xfer_start; done pulses next.
// Backpressure: none; xfer_start is ignored (not queued) while busy or in the done cycle.
module gpio_cfg_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_GPIO = NUM_GPIO_DEF,
  parameter int CLK_DIV  = 2,
  parameter int IDX_W    = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             xfer_start,
  output logic             busy,
  output logic             done,
  output logic             cfg_rd,
  output logic [IDX_W-1:0] cfg_idx,
  input  logic [CFG_W-1:0] cfg_data_1,
  input  logic [CFG_W-1:0] cfg_data_2,
  output logic             serial_clock,
  output logic             serial_load,
  output logic             serial_resetn,
  output logic             serial_data_1,
  output logic             serial_data_2
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CFG_W-1:0]     sh1_q, sh1_d;
  logic [CFG_W-1:0]     sh2_q, sh2_d;
  logic [BIT_CNT_W-1:0] bits_q, bits_d;
  logic [DIV_W-1:0]     ld_cnt_q, ld_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_q, rd_d;
  logic                 load_q, load_d;
  logic                 sd1_q, sd1_d;
  logic                 sd2_q, sd2_d;
  logic                 resetn_q;
  logic                 sclk_rise, sclk_fall;

  // The bit clock only runs while shifting, so it is low in every other state.
  gpio_cfg_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .en   (state_q == ST_SHIFT),
    .sclk (serial_clock),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Sequencer next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    bits_d   = bits_q;
    ld_cnt_d = ld_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer_start) begin
          state_d = ST_FETCH;
          // Farthest block first: its word has to travel the whole chain.
          idx_d   = IDX_W'(NUM_GPIO - 1);
        end
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        sh1_d   = cfg_data_1;
        sh2_d   = cfg_data_2;
        bits_d  = BIT_CNT_W'(CFG_W);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // bits_q counts bits not yet sampled downstream; it drops on each rising edge.
        if (sclk_rise) begin
          bits_d = bits_q - BIT_CNT_W'(1);
        end
        if (sclk_fall) begin
          sh1_d = {sh1_q[CFG_W-2:0], 1'b0};
          sh2_d = {sh2_q[CFG_W-2:0], 1'b0};
          if (bits_q == '0) begin
            if (idx_q != '0) begin
              idx_d   = idx_q - IDX_W'(1);
              state_d = ST_FETCH;
            end else begin
              ld_cnt_d = '0;
              state_d  = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        if (ld_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          ld_cnt_d = ld_cnt_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_CAPTURE) ||
             (state_d == ST_SHIFT) || (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
    rd_d   = (state_d == ST_FETCH);
    load_d = (state_d == ST_LOAD);
    // Data follows the shift-register MSB while shifting, parks at 0 when idle, else holds.
    if (state_d == ST_SHIFT) begin
      sd1_d = sh1_d[CFG_W-1];
      sd2_d = sh2_d[CFG_W-1];
    end else if ((state_d == ST_DONE) || (state_d == ST_IDLE)) begin
      sd1_d = 1'b0;
      sd2_d = 1'b0;
    end else begin
      sd1_d = sd1_q;
      sd2_d = sd2_q;
    end
  end

  // State and registered outputs; reset also holds the chains in their default state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      bits_q   <= '0;
      ld_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      load_q   <= 1'b0;
      sd1_q    <= 1'b0;
      sd2_q    <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      bits_q   <= bits_d;
      ld_cnt_q <= ld_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      sd1_q    <= sd1_d;
      sd2_q    <= sd2_d;
      resetn_q <= 1'b1;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_rd        = rd_q;
  assign cfg_idx       = idx_q;
  assign serial_load   = load_q;
  assign serial_resetn = resetn_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench for gpio_cfg_serial_loader: three configurations (default, single GPIO at CLK_DIV=1, CLK_DIV=3).
// Stimulus pushes expected bit streams and per-transfer records; a negedge monitor pops and compares.
module tb_gpio_cfg_serial_loader;
  import gpio_cfg_pkg::*;

  typedef struct {
    int busy_len;
    int edges;
    int rds;
    int load_len;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [3];
  logic       start  [3];
  logic       busy   [3];
  logic       done   [3];
  logic       rd     [3];
  logic       sclk   [3];
  logic       sload  [3];
  logic       sresetn[3];
  logic       sd1    [3];
  logic       sd2    [3];
  logic [4:0] idx    [3];
  logic [9:0] d1     [3];
  logic [9:0] d2     [3];

  int n_chk  = 0;
  int n_fail = 0;

  xfer_t      rec_q [3][$];
  logic [1:0] bit_q [3][$];
  int         div   [3] = '{2, 1, 3};

  gpio_cfg_serial_loader #(.NUM_GPIO(19), .CLK_DIV(2), .IDX_W(5)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .xfer_start(start[0]), .busy(busy[0]), .done(done[0]),
    .cfg_rd(rd[0]), .cfg_idx(idx[0]), .cfg_data_1(d1[0]), .cfg_data_2(d2[0]),
    .serial_clock(sclk[0]), .serial_load(sload[0]), .serial_resetn(sresetn[0]),
    .serial_data_1(sd1[0]), .serial_data_2(sd2[0]));

  gpio_cfg_serial_loader #(.NUM_GPIO(1), .CLK_DIV(1), .IDX_W(5)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .xfer_start(start[1]), .busy(busy[1]), .done(done[1]),
    .cfg_rd(rd[1]), .cfg_idx(idx[1]), .cfg_data_1(d1[1]), .cfg_data_2(d2[1]),
    .serial_clock(sclk[1]), .serial_load(sload[1]), .serial_resetn(sresetn[1]),
    .serial_data_1(sd1[1]), .serial_data_2(sd2[1]));

  gpio_cfg_serial_loader #(.NUM_GPIO(19), .CLK_DIV(3), .IDX_W(5)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst[2]), .xfer_start(start[2]), .busy(busy[2]), .done(done[2]),
    .cfg_rd(rd[2]), .cfg_idx(idx[2]), .cfg_data_1(d1[2]), .cfg_data_2(d2[2]),
    .serial_clock(sclk[2]), .serial_load(sload[2]), .serial_resetn(sresetn[2]),
    .serial_data_1(sd1[2]), .serial_data_2(sd2[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Register file model: data valid the cycle after cfg_rd, scrambled otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd[k] === 1'b1) begin
        if (k == 1) begin
          d1[k] <= 10'h2AA;
          d2[k] <= 10'h155;
        end else begin
          d1[k] <= 10'h200 | 10'(idx[k]);
          d2[k] <= 10'h0FF ^ 10'(idx[k]);
        end
      end else begin
        d1[k] <= 10'($urandom);
        d2[k] <= 10'($urandom);
      end
    end
  end

  // Monitor
  int   busy_len[3], edges[3], rds[3], load_len[3], high_run[3], last_rise[3], done_cnt[3];
  int   cyc = 0;
  logic busy_p[3], sclk_p[3], sd1_p[3], sd2_p[3], rd_since[3];

  initial begin
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
  end

  always @(negedge clk) begin
    logic [1:0] e;
    xfer_t      r;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst[k] !== 1'b0) begin
        busy_len[k] = 0; edges[k] = 0; rds[k] = 0; load_len[k] = 0; high_run[k] = 0;
        last_rise[k] = -1; rd_since[k] = 1'b0;
        busy_p[k] = 1'b0; sclk_p[k] = 1'b0; sd1_p[k] = 1'b0; sd2_p[k] = 1'b0;
      end else begin
        if (busy[k] && !busy_p[k]) begin
          busy_len[k] = 0; edges[k] = 0; rds[k] = 0; load_len[k] = 0; high_run[k] = 0;
          last_rise[k] = -1; rd_since[k] = 1'b0;
        end
        if (busy[k]) begin
          busy_len[k]++;
          chk($sformatf("clk_load_overlap[%0d]", k), int'(sclk[k] & sload[k]), 0);
        end
        if (rd[k]) begin
          rds[k]++;
          rd_since[k] = 1'b1;
        end
        if (sload[k]) load_len[k]++;
        if (sclk[k] && !sclk_p[k]) begin
          edges[k]++;
          if (last_rise[k] >= 0 && !rd_since[k])
            chk($sformatf("sclk_period[%0d]", k), cyc - last_rise[k], 2 * div[k]);
          last_rise[k] = cyc;
          rd_since[k]  = 1'b0;
          chk($sformatf("bit_expected[%0d]", k), int'(bit_q[k].size() > 0), 1);
          if (bit_q[k].size() > 0) begin
            e = bit_q[k].pop_front();
            chk($sformatf("chain_bits[%0d] edge %0d", k, edges[k]), int'({sd1[k], sd2[k]}), int'(e));
          end
        end
        if (sclk[k] && sclk_p[k])
          chk($sformatf("data_stable_high[%0d]", k), int'({sd1[k], sd2[k]}), int'({sd1_p[k], sd2_p[k]}));
        if (sclk[k]) high_run[k]++;
        if (!sclk[k] && sclk_p[k]) begin
          chk($sformatf("high_phase_len[%0d]", k), high_run[k], div[k]);
          high_run[k] = 0;
        end
        if (done[k]) begin
          done_cnt[k]++;
          chk($sformatf("done_expected[%0d]", k), int'(rec_q[k].size() > 0), 1);
          if (rec_q[k].size() > 0) begin
            r = rec_q[k].pop_front();
            chk($sformatf("busy_len[%0d]", k), busy_len[k], r.busy_len);
            chk($sformatf("rise_edges[%0d]", k), edges[k], r.edges);
            chk($sformatf("cfg_rd_count[%0d]", k), rds[k], r.rds);
            chk($sformatf("load_len[%0d]", k), load_len[k], r.load_len);
          end
        end
        busy_p[k] = busy[k];
        sclk_p[k] = sclk[k];
        sd1_p[k]  = sd1[k];
        sd2_p[k]  = sd2[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Expected streams: farthest index first, MSB first within each word.
  task automatic push_xfer(input int k, input int n, input int blen, input int edg, input int ld);
    xfer_t      r;
    logic [9:0] w1, w2;
    r.busy_len = blen; r.edges = edg; r.rds = n; r.load_len = ld;
    rec_q[k].push_back(r);
    for (int i = n - 1; i >= 0; i--) begin
      if (k == 1) begin
        w1 = 10'h2AA; w2 = 10'h155;
      end else begin
        w1 = 10'h200 | 10'(i); w2 = 10'h0FF ^ 10'(i);
      end
      for (int b = 9; b >= 0; b--) bit_q[k].push_back({w1[b], w2[b]});
    end
  endtask

  task automatic wait_done(input int k, input int limit);
    for (int c = 0; c < limit; c++) begin
      tick();
      if (done[k] === 1'b1) break;
    end
    chk($sformatf("done_within_budget[%0d]", k), int'(done[k]), 1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; d1[k] = '0; d2[k] = '0;
    end
    repeat (3) tick();
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_cfg_rd", int'(rd[0]), 0);
    chk("rst_cfg_idx", int'(idx[0]), 0);
    chk("rst_sclk", int'(sclk[0]), 0);
    chk("rst_sload", int'(sload[0]), 0);
    chk("rst_sd1", int'(sd1[0]), 0);
    chk("rst_sd2", int'(sd2[0]), 0);
    chk("rst_sresetn", int'(sresetn[0]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("sresetn_after_release[%0d]", k), int'(sresetn[k]), 1);

    // Full loads on all three configurations at once.
    push_xfer(0, 19, 800, 190, 2);
    push_xfer(1, 1, 23, 10, 1);
    push_xfer(2, 19, 1181, 190, 3);
    for (int k = 0; k < 3; k++) start[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    chk("busy_after_start", int'(busy[0]), 1);
    chk("first_idx", int'(idx[0]), 18);
    chk("first_cfg_rd", int'(rd[0]), 1);
    wait_done(1, 40);
    wait_done(0, 900);
    wait_done(2, 1300);
    tick();
    chk("idle_busy", int'(busy[0]), 0);
    chk("idle_sd1", int'(sd1[0]), 0);

    // Repeated xfer_start during a transfer is ignored.
    push_xfer(0, 19, 800, 190, 2);
    pulse(0);
    repeat (3) tick();
    pulse(0);
    repeat (394) tick();
    pulse(0);
    wait_done(0, 900);
    repeat (5) tick();

    // Back-to-back: start in the cycle right after done.
    push_xfer(0, 19, 800, 190, 2);
    pulse(0);
    wait_done(0, 900);
    push_xfer(0, 19, 800, 190, 2);
    tick();
    pulse(0);
    chk("b2b_idx", int'(idx[0]), 18);
    chk("b2b_cfg_rd", int'(rd[0]), 1);
    wait_done(0, 900);
    repeat (5) tick();

    // Reset in the middle of a transfer.
    push_xfer(0, 19, 800, 190, 2);
    pulse(0);
    repeat (298) tick();
    rst[0] = 1'b1;
    tick();
    chk("midrst_sresetn", int'(sresetn[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_sclk", int'(sclk[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    rst[0] = 1'b0;
    rec_q[0].delete();
    bit_q[0].delete();
    tick();
    chk("midrst_sresetn_release", int'(sresetn[0]), 1);
    repeat (100) tick();
    chk("midrst_still_idle", int'(busy[0]), 0);

    chk("done_count[0]", done_cnt[0], 4);
    chk("done_count[1]", done_cnt[1], 1);
    chk("done_count[2]", done_cnt[2], 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("records_left[%0d]", k), rec_q[k].size(), 0);
      chk($sformatf("bits_left[%0d]", k), bit_q[k].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
